// File: rtl/fetch_stall_ctrl.sv
// fetch_stall_ctrl
// Fetch-side pipeline controller for the 5-stage CPU. Owns the PC register
// and the IF/ID pipeline register, reacts to load-use stalls and to taken
// branches resolved in Decode, inserts ID/EX bubbles, and drains/freezes
// the pipeline when the halt instruction reaches Decode. Also keeps stall
// statistics for debug.
//
// Ports:
//   CLK, RST        clock, synchronous active-high reset
//   Stall           load-use stall request from hazard detection
//   Branch_D        taken branch/jump resolved in Decode
//   BranchTarget_D  target PC for Branch_D
//   Instr_F         instruction fetched at PC_F
//   PC_F            current fetch PC
//   Instr_D         IF/ID instruction
//   PCPlus4_D       IF/ID PC+4
//   Valid_D         IF/ID holds a real instruction (0 = bubble)
//   FlushE          clear ID/EX on the next edge (combinational)
//   Halted          pipeline frozen after halt drain
//   StallCnt        saturating count of stalled cycles since reset
//   StallErr        sticky flag, a stall run reached MAX_STALL
module fetch_stall_ctrl #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter logic [31:0] HALT_INSTR   = 32'hFFFF_FFFF,
    parameter int          DRAIN_CYCLES = 4,
    parameter int          MAX_STALL    = 8
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        Stall,
    input  logic        Branch_D,
    input  logic [31:0] BranchTarget_D,
    input  logic [31:0] Instr_F,
    output logic [31:0] PC_F,
    output logic [31:0] Instr_D,
    output logic [31:0] PCPlus4_D,
    output logic        Valid_D,
    output logic        FlushE,
    output logic        Halted,
    output logic [15:0] StallCnt,
    output logic        StallErr
);

    localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES + 1) : 1;
    localparam int RW = $clog2(MAX_STALL + 1);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    state_t          state_r;
    state_t          state_next_s;
    logic [DW-1:0]   drain_cnt_r;
    logic [DW-1:0]   drain_next_s;
    logic [RW-1:0]   run_cnt_r;
    logic [31:0]     pc_r;
    logic [31:0]     instr_d_r;
    logic [31:0]     pcplus4_d_r;
    logic            valid_d_r;
    logic            halted_r;
    logic [15:0]     stall_cnt_r;
    logic            stall_err_r;
    logic            flush_s;
    logic            halt_seen_s;
    logic [31:0]     pc_plus4_s;

    assign pc_plus4_s  = pc_r + 32'd4;
    assign halt_seen_s = valid_d_r && (instr_d_r == HALT_INSTR);

    // FSM state and drain counter register
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r     <= ST_RUN;
            drain_cnt_r <= '0;
        end else begin
            state_r     <= state_next_s;
            drain_cnt_r <= drain_next_s;
        end
    end

    // FSM next-state and drain counter logic
    always_comb begin
        state_next_s = state_r;
        drain_next_s = drain_cnt_r;
        case (state_r)
            ST_RUN: begin
                // Stall and branch both outrank halt detection
                if (!Stall && !Branch_D && halt_seen_s) begin
                    state_next_s = ST_DRAIN;
                    drain_next_s = DW'(DRAIN_CYCLES - 1);
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (drain_cnt_r == '0) begin
                    state_next_s = ST_HALT;
                end else begin
                    drain_next_s = drain_cnt_r - DW'(1);
                end
            end
            ST_HALT: begin
                state_next_s = ST_HALT;
            end
            default: begin
                state_next_s = ST_RUN;
                drain_next_s = '0;
            end
        endcase
    end

    // FSM outputs: ID/EX bubble request only while running
    always_comb begin
        flush_s = 1'b0;
        case (state_r)
            ST_RUN:   flush_s = Stall;
            ST_DRAIN: flush_s = 1'b0;
            ST_HALT:  flush_s = 1'b0;
            default:  flush_s = 1'b0;
        endcase
    end

    // PC, IF/ID register, halt flag and stall statistics
    always_ff @(posedge CLK) begin
        if (RST) begin
            pc_r        <= RESET_PC;
            instr_d_r   <= 32'd0;
            pcplus4_d_r <= 32'd0;
            valid_d_r   <= 1'b0;
            halted_r    <= 1'b0;
            stall_cnt_r <= 16'd0;
            stall_err_r <= 1'b0;
            run_cnt_r   <= '0;
        end else begin
            halted_r <= (state_next_s == ST_HALT);
            case (state_r)
                ST_RUN: begin
                    if (Stall) begin
                        // Hold PC and IF/ID; a branch this cycle is re-evaluated later
                        if (stall_cnt_r != 16'hFFFF) begin
                            stall_cnt_r <= stall_cnt_r + 16'd1;
                        end
                        if (run_cnt_r != RW'(MAX_STALL)) begin
                            run_cnt_r <= run_cnt_r + RW'(1);
                        end
                        if (run_cnt_r == RW'(MAX_STALL - 1)) begin
                            stall_err_r <= 1'b1;
                        end
                    end else if (Branch_D) begin
                        // Squash the wrong-path fetch, no delay slot
                        pc_r        <= BranchTarget_D;
                        instr_d_r   <= 32'd0;
                        pcplus4_d_r <= 32'd0;
                        valid_d_r   <= 1'b0;
                        run_cnt_r   <= '0;
                    end else if (halt_seen_s) begin
                        instr_d_r <= 32'd0;
                        valid_d_r <= 1'b0;
                        run_cnt_r <= '0;
                    end else begin
                        pc_r        <= pc_plus4_s;
                        instr_d_r   <= Instr_F;
                        pcplus4_d_r <= pc_plus4_s;
                        valid_d_r   <= 1'b1;
                        run_cnt_r   <= '0;
                    end
                end
                ST_DRAIN: begin
                    run_cnt_r <= '0;
                end
                ST_HALT: begin
                    run_cnt_r <= '0;
                end
                default: begin
                    run_cnt_r <= '0;
                end
            endcase
        end
    end

    assign PC_F      = pc_r;
    assign Instr_D   = instr_d_r;
    assign PCPlus4_D = pcplus4_d_r;
    assign Valid_D   = valid_d_r;
    assign FlushE    = flush_s;
    assign Halted    = halted_r;
    assign StallCnt  = stall_cnt_r;
    assign StallErr  = stall_err_r;

endmodule
